// File: rtl/tick_counter.sv
// tick_counter: prescaled up/down counter with clear, load, wrap/saturate
// and a terminal-count pulse, all in the clkin domain.
module tick_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DIV      = 25000000,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  // Prescaler needs at least one bit even when DIV is 1.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [PW-1:0]    prescale;
  logic [PW-1:0]    ps_next;
  logic [WIDTH-1:0] cnt_next;
  logic             tick_next;
  logic             tc_next;
  logic             step_c;

  // Next-state: clear > load > step > hold.
  always_comb begin
    ps_next   = prescale;
    cnt_next  = count;
    tick_next = 1'b0;
    tc_next   = 1'b0;
    step_c    = 1'b0;

    if (clear) begin
      ps_next  = '0;
      cnt_next = '0;
    end else if (load) begin
      ps_next  = '0;
      cnt_next = load_val;
    end else if (en) begin
      if (prescale == PS_LAST) begin
        ps_next = '0;
        step_c  = 1'b1;
      end else begin
        ps_next = prescale + PW'(1);
      end
    end

    if (step_c) begin
      tick_next = 1'b1;
      if (dir) begin
        if (count == CNT_MAX) begin
          tc_next  = 1'b1;
          cnt_next = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_next = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          tc_next  = 1'b1;
          cnt_next = SATURATE ? '0 : CNT_MAX;
        end else begin
          cnt_next = count - WIDTH'(1);
        end
      end
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      count    <= '0;
      tick     <= 1'b0;
      tc       <= 1'b0;
    end else begin
      prescale <= ps_next;
      count    <= cnt_next;
      tick     <= tick_next;
      tc       <= tc_next;
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: scoreboard bench for three tick_counter configurations
// (DIV=4 wrap, DIV=4 saturate, DIV=1 wrap) sharing one stimulus stream.
module tb_tick_counter;

  localparam int unsigned W = 4;

  logic         clkin = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt_a, cnt_s, cnt_d;
  logic         tick_a, tick_s, tick_d;
  logic         tc_a, tc_s, tc_d;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] s;
    logic [5:0] d;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = wrap/DIV4, 1 = sat/DIV4, 2 = wrap/DIV1.
  int m_cnt[3];
  int m_ps[3];
  bit m_tick[3];
  bit m_tc[3];

  always #5 clkin = ~clkin;

  tick_counter #(.WIDTH(W), .DIV(4), .SATURATE(1'b0)) dut_a (
    .clkin(clkin), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_a), .tick(tick_a), .tc(tc_a));

  tick_counter #(.WIDTH(W), .DIV(4), .SATURATE(1'b1)) dut_s (
    .clkin(clkin), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_s), .tick(tick_s), .tc(tc_s));

  tick_counter #(.WIDTH(W), .DIV(1), .SATURATE(1'b0)) dut_d (
    .clkin(clkin), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_d), .tick(tick_d), .tc(tc_d));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit sat_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [5:0] pack_exp(input int i);
    return {4'(m_cnt[i]), m_tick[i], m_tc[i]};
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_tick[i] = 1'b0; m_tc[i] = 1'b0;
    end
  endtask

  // Model one clkin edge for instance i using the currently driven inputs.
  task automatic model_edge(input int i);
    int nxt;
    bit stepped;
    stepped = 1'b0;
    m_tick[i] = 1'b0;
    m_tc[i] = 1'b0;
    if (rst || clear) begin
      m_cnt[i] = 0; m_ps[i] = 0;
    end else if (load) begin
      m_cnt[i] = int'(load_val); m_ps[i] = 0;
    end else if (en) begin
      m_ps[i] = m_ps[i] + 1;
      if (m_ps[i] >= div_of(i)) begin
        m_ps[i] = 0;
        stepped = 1'b1;
      end
    end
    if (stepped) begin
      m_tick[i] = 1'b1;
      nxt = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
      if (nxt < 0 || nxt > 15) begin
        m_tc[i] = 1'b1;
        nxt = sat_of(i) ? m_cnt[i] : (nxt + 16) % 16;
      end
      m_cnt[i] = nxt;
    end
  endtask

  // Push the expected result for the coming edge, clock, then compare.
  task automatic run_cycle();
    exp_t e;
    for (int i = 0; i < 3; i++) model_edge(i);
    e.a = pack_exp(0);
    e.s = pack_exp(1);
    e.d = pack_exp(2);
    sb_q.push_back(e);
    @(posedge clkin);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_wrap", {26'd0, cnt_a, tick_a, tc_a}, {26'd0, e.a});
    check_eq("sb_sat",  {26'd0, cnt_s, tick_s, tc_s}, {26'd0, e.s});
    check_eq("sb_div1", {26'd0, cnt_d, tick_d, tc_d}, {26'd0, e.d});
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_zero();
    run_n(2);
    check_eq("rst_count", 32'(cnt_a), 32'd0);

    // Count up from reset release.
    rst = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      run_cycle();
      if (k % 4 == 0) begin
        check_eq("up_count", 32'(cnt_a), 32'(k / 4));
        check_eq("up_tick", 32'(tick_a), 32'd1);
        check_eq("up_tc", 32'(tc_a), 32'd0);
      end
      check_eq("div1_tick", 32'(tick_d), 32'd1);
      check_eq("div1_count", 32'(cnt_d), 32'(k));
    end

    // Load 14 then wrap through MAX.
    load_val = 4'd14; load = 1'b1;
    run_cycle();
    check_eq("load_count", 32'(cnt_a), 32'd14);
    check_eq("load_tick", 32'(tick_a), 32'd0);
    load = 1'b0;
    run_n(4);
    check_eq("to15", 32'(cnt_a), 32'd15);
    run_n(4);
    check_eq("wrap_count", 32'(cnt_a), 32'd0);
    check_eq("wrap_tick", 32'(tick_a), 32'd1);
    check_eq("wrap_tc", 32'(tc_a), 32'd1);
    check_eq("sat_hi_count", 32'(cnt_s), 32'd15);
    check_eq("sat_hi_tc", 32'(tc_s), 32'd1);
    run_n(4);
    check_eq("after_wrap", 32'(cnt_a), 32'd1);
    check_eq("after_wrap_tc", 32'(tc_a), 32'd0);
    check_eq("sat_hi_again", 32'(tc_s), 32'd1);

    // Count down through zero.
    clear = 1'b1;
    run_cycle();
    clear = 1'b0; dir = 1'b0;
    run_n(4);
    check_eq("down_wrap", 32'(cnt_a), 32'd15);
    check_eq("down_wrap_tc", 32'(tc_a), 32'd1);
    check_eq("sat_lo_count", 32'(cnt_s), 32'd0);
    check_eq("sat_lo_tc", 32'(tc_s), 32'd1);
    run_n(4);
    check_eq("sat_lo_count2", 32'(cnt_s), 32'd0);
    check_eq("sat_lo_tc2", 32'(tc_s), 32'd1);
    check_eq("sat_lo_tick2", 32'(tick_s), 32'd1);
    check_eq("down_14", 32'(cnt_a), 32'd14);

    // Pause en with prescaler at 2.
    clear = 1'b1;
    run_cycle();
    clear = 1'b0; dir = 1'b1;
    run_n(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      check_eq("pause_count", 32'(cnt_a), 32'd0);
      check_eq("pause_tick", 32'(tick_d), 32'd0);
    end
    en = 1'b1;
    run_cycle();
    check_eq("resume1", 32'(cnt_a), 32'd0);
    run_cycle();
    check_eq("resume2", 32'(cnt_a), 32'd1);
    check_eq("resume2_tick", 32'(tick_a), 32'd1);

    // clear beats load; load beats step.
    clear = 1'b1; load = 1'b1; load_val = 4'd9;
    run_cycle();
    check_eq("clr_vs_load", 32'(cnt_a), 32'd0);
    clear = 1'b0; load = 1'b0;
    run_n(3);
    load = 1'b1;
    run_cycle();
    check_eq("load_on_step", 32'(cnt_a), 32'd9);
    check_eq("load_on_step_tick", 32'(tick_a), 32'd0);
    load = 1'b0;
    run_n(3);
    check_eq("post_load3", 32'(cnt_a), 32'd9);
    run_cycle();
    check_eq("post_load4", 32'(cnt_a), 32'd10);

    // Asynchronous reset mid-period with count=7.
    load_val = 4'd7; load = 1'b1;
    run_cycle();
    load = 1'b0;
    run_n(2);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_count", 32'(cnt_a), 32'd0);
    check_eq("arst_tick_d", 32'(tick_d), 32'd0);
    check_eq("arst_count_d", 32'(cnt_d), 32'd0);
    model_zero();
    run_cycle();
    rst = 1'b0;
    run_n(3);
    check_eq("arst_rel3", 32'(cnt_a), 32'd0);
    run_cycle();
    check_eq("arst_rel4", 32'(cnt_a), 32'd1);
    check_eq("arst_rel4_tick", 32'(tick_a), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 40) == 0);
      load = ($urandom_range(0, 25) == 0);
      load_val = 4'($urandom_range(0, 15));
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised successor to the board-level prescaler plus LED counter.
- Fully synchronous, single clock domain; no derived clocks.
- The prescaler produces an internal enable every DIV enabled cycles, and that enable steps a WIDTH-bit counter.
- Direction, wrap/saturate mode, clear, load and a terminal-count pulse are selectable. The block drives LED banks and feeds other board demos directly from clkin.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- DIV, 25000000: prescale period in clkin cycles; one step every DIV enabled cycles; legal range DIV >= 1.
- SATURATE, 0: 0 = count wraps at the bounds; 1 = count holds at the bound.
- Internal prescale register width is $clog2(DIV), minimum 1 bit; this is a localparam, not user-set.

Ports:
- clkin  input  1  system clock, 25 MHz on the board.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  when high, the prescaler advances; when low, the prescaler and counter hold.
- dir  input  1  step direction: 1 = up (+1), 0 = down (-1); sampled on the step cycle.
- clear  input  1  synchronous clear of the counter and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value written by load.
- count  output  WIDTH  current counter value; registered.
- tick  output  1  one-cycle pulse, high in the cycle the newly stepped count is first visible.
- tc  output  1  one-cycle terminal-count pulse, coincident with tick.

Behaviour:
- Reset (rst high, asynchronous):
  - count=0, prescaler=0, tick=0, tc=0.
  - Takes effect immediately, even mid-operation.
  - Release is synchronous to clkin; the first step occurs DIV enabled cycles after release.
- Priority per clkin edge: clear > load > step > hold.
- clear:
  - count<=0, prescaler<=0, tick<=0, tc<=0.
  - Ignores en.
- load (clear low):
  - count<=load_val, prescaler<=0, tick<=0, tc<=0.
  - Ignores en. The next step occurs exactly DIV enabled cycles later.
- Prescaler (en high, no clear/load):
  - If prescaler==DIV-1: prescaler<=0 and a step occurs on this edge. Otherwise prescaler<=prescaler+1.
  - DIV=1: a step occurs on every enabled edge.
- en low: prescaler, count hold; tick<=0, tc<=0. Re-asserting en resumes from the held prescaler value, with no restart.
- Step (tick<=1 on the same edge):
  - Up, count<MAX (MAX = 2^WIDTH-1): count<=count+1, tc<=0.
  - Up, count==MAX:
    - SATURATE=0: count<=0, tc<=1.
    - SATURATE=1: count holds at MAX, tc<=1.
  - Down, count>0: count<=count-1, tc<=0.
  - Down, count==0:
    - SATURATE=0: count<=MAX, tc<=1.
    - SATURATE=1: count holds at 0, tc<=1.
  - Saturated hold: tc re-pulses on every further step while held at the bound; tick still pulses.
- Non-step edges with no clear/load: tick<=0, tc<=0. tick and tc are never high longer than one cycle when DIV>1.
- Latency: count, tick and tc update on the same edge; no combinational path from any input to any output.
- dir changing between steps has no effect until the next step edge. Toggling dir at a bound applies only the new direction.
- Arithmetic is modulo 2^WIDTH; no overflow beyond WIDTH bits is stored.

Test Plan:
- WIDTH=4, DIV=4, SATURATE=0, en=1, dir=1 from reset -> count reaches 1,2,3 at cycles 4,8,12 after reset release; tick is high exactly on those cycles; tc=0.
- Same config, load_val=14 loaded, then run -> count 15 four cycles after load; 0 four cycles later with tick=1, tc=1; then 1 with tc=0.
- dir=0, count=0, SATURATE=0 -> next step gives count=15, tc=1. Repeat with SATURATE=1 -> count stays 0, tc=1 on every step, tick keeps pulsing.
- en dropped for 10 cycles when prescaler=2, then re-raised -> count unchanged while low; next step comes 2 enabled cycles after re-assert; tick/tc=0 throughout the pause.
- clear and load asserted on the same edge with load_val=9 -> count=0, prescaler=0. load alone on a would-be step edge -> count=9, tick=0.
- rst pulsed asynchronously mid-period with count=7, not aligned to clkin -> count, tick, tc go 0 immediately. After release, first step comes after DIV cycles. DIV=1 variant: count increments every cycle, tick held high continuously.
